// File: rtl/my_down_timer_163.sv
// Synchronous presettable down-counter with terminal-count flags, optional
// auto-reload from the last preset and optional BCD (decade) wrap.
module my_down_timer_163 #(
  parameter int WIDTH       = 4,
  parameter int AUTO_RELOAD = 0,
  parameter int DECADE      = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             LDN,
  input  logic             ENP,
  input  logic             ENT,
  output logic [WIDTH-1:0] Q,
  output logic             BON,
  output logic             ZERO,
  output logic             DONE,
  output logic [WIDTH-1:0] RLD
);

  localparam logic [WIDTH-1:0] WRAP_VAL = (DECADE != 0) ? WIDTH'(9) : {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] rld_nxt;
  logic             done_nxt;

  // Priority below CLR: load, then count, then hold.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    q_nxt    = Q;
    rld_nxt  = RLD;
    done_nxt = 1'b0;
    if (!LDN) begin
      q_nxt   = D;
      rld_nxt = D;
    end else if (ENP && ENT) begin
      if (Q != '0) begin
        q_nxt    = Q - WIDTH'(1);
        done_nxt = (Q == WIDTH'(1));
      end else if (AUTO_RELOAD != 0) begin
        q_nxt = RLD;
      end else begin
        q_nxt = WRAP_VAL;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (CLR) begin
      Q    <= '0;
      RLD  <= '0;
      DONE <= 1'b0;
    end else begin
      Q    <= q_nxt;
      RLD  <= rld_nxt;
      DONE <= done_nxt;
    end
  end

  assign ZERO = (Q == '0);
  assign BON  = ~(ZERO & ENT);

endmodule

// File: tb/tb_my_down_timer_163.sv
// Self-checking bench: three parameter flavours share one stimulus stream,
// plus a two-stage cascade checked as a single 8-bit down counter.
module tb_my_down_timer_163;

  logic       clk = 1'b0;
  logic       clr, ldn, enp, ent;
  logic [3:0] d;
  logic [3:0] q_o   [3];
  logic [3:0] rld_o [3];
  logic       bon_o [3];
  logic       zero_o[3];
  logic       done_o[3];

  logic       cclr, cldn, cenp, cent, hi_ent;
  logic [7:0] cd;
  logic [3:0] lo_q, hi_q, lo_rld, hi_rld;
  logic       lo_bon, hi_bon, lo_zero, hi_zero, lo_done, hi_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: index 0 binary wrap, 1 decade wrap, 2 auto-reload
  localparam int AR  [3] = '{0, 0, 1};
  localparam int DEC [3] = '{0, 1, 0};
  int mq   [3];
  int mrld [3];
  bit mdone[3];
  int cm;

  always #5 clk = ~clk;

  my_down_timer_163 #(.WIDTH(4), .AUTO_RELOAD(0), .DECADE(0)) dut_bin (
    .CLK(clk), .CLR(clr), .D(d), .LDN(ldn), .ENP(enp), .ENT(ent),
    .Q(q_o[0]), .BON(bon_o[0]), .ZERO(zero_o[0]), .DONE(done_o[0]), .RLD(rld_o[0]));

  my_down_timer_163 #(.WIDTH(4), .AUTO_RELOAD(0), .DECADE(1)) dut_dec (
    .CLK(clk), .CLR(clr), .D(d), .LDN(ldn), .ENP(enp), .ENT(ent),
    .Q(q_o[1]), .BON(bon_o[1]), .ZERO(zero_o[1]), .DONE(done_o[1]), .RLD(rld_o[1]));

  my_down_timer_163 #(.WIDTH(4), .AUTO_RELOAD(1), .DECADE(0)) dut_ar (
    .CLK(clk), .CLR(clr), .D(d), .LDN(ldn), .ENP(enp), .ENT(ent),
    .Q(q_o[2]), .BON(bon_o[2]), .ZERO(zero_o[2]), .DONE(done_o[2]), .RLD(rld_o[2]));

  assign hi_ent = ~lo_bon;

  my_down_timer_163 #(.WIDTH(4), .AUTO_RELOAD(0), .DECADE(0)) dut_lo (
    .CLK(clk), .CLR(cclr), .D(cd[3:0]), .LDN(cldn), .ENP(cenp), .ENT(cent),
    .Q(lo_q), .BON(lo_bon), .ZERO(lo_zero), .DONE(lo_done), .RLD(lo_rld));

  my_down_timer_163 #(.WIDTH(4), .AUTO_RELOAD(0), .DECADE(0)) dut_hi (
    .CLK(clk), .CLR(cclr), .D(cd[7:4]), .LDN(cldn), .ENP(cenp), .ENT(hi_ent),
    .Q(hi_q), .BON(hi_bon), .ZERO(hi_zero), .DONE(hi_done), .RLD(hi_rld));

  // One clock edge: advance the models with the inputs seen at that edge,
  // then settle 1 time unit so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        mq[i] = 0; mrld[i] = 0; mdone[i] = 0;
      end else if (!ldn) begin
        mq[i] = d; mrld[i] = d; mdone[i] = 0;
      end else if (enp && ent) begin
        if (mq[i] > 0) begin
          mq[i]    = mq[i] - 1;
          mdone[i] = (mq[i] == 0);
        end else begin
          mq[i]    = AR[i] ? mrld[i] : (DEC[i] ? 9 : 15);
          mdone[i] = 0;
        end
      end else begin
        mdone[i] = 0;
      end
    end
    if (cclr)             cm = 0;
    else if (!cldn)       cm = cd;
    else if (cenp && cent) cm = (cm + 255) % 256;
    #1;
  endtask

  task automatic test_reset();
    clr = 1; cclr = 1; ent = 0; enp = 0; ldn = 1;
    step();
    clr = 0; cclr = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_o[i] !== 4'd0 || rld_o[i] !== 4'd0 || done_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got q=%0d rld=%0d done=%b, expected 0/0/0",
                 i, q_o[i], rld_o[i], done_o[i]);
      end
      checks++;
      if (zero_o[i] !== 1'b1 || bon_o[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got zero=%b bon=%b, expected 1/1", i, zero_o[i], bon_o[i]);
      end
    end
    ent = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bon_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_bon_ent[%0d]: got %b expected 0", i, bon_o[i]);
      end
    end
    checks++;
    if (lo_q !== 4'd0 || hi_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_cascade: got %h%h expected 00", hi_q, lo_q);
    end
  endtask

  task automatic test_binary_wrap();
    int exp_q[5] = '{2, 1, 0, 15, 14};
    ldn = 0; d = 4'd3; enp = 1; ent = 1;
    step();
    ldn = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (q_o[0] !== 4'(exp_q[k]) || done_o[0] !== (exp_q[k] == 0)) begin
        errors++;
        $display("FAIL binary_step%0d: got q=%0d done=%b expected q=%0d done=%b",
                 k, q_o[0], done_o[0], exp_q[k], exp_q[k] == 0);
      end
    end
  endtask

  task automatic test_decade();
    int exp_a[3] = '{0, 9, 8};
    int exp_b[4] = '{11, 10, 9, 8};
    ldn = 0; d = 4'd1; enp = 1; ent = 1;
    step();
    ldn = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (q_o[1] !== 4'(exp_a[k]) || done_o[1] !== (k == 0)) begin
        errors++;
        $display("FAIL decade_a%0d: got q=%0d done=%b expected q=%0d done=%b",
                 k, q_o[1], done_o[1], exp_a[k], k == 0);
      end
    end
    ldn = 0; d = 4'd12;
    step();
    ldn = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (q_o[1] !== 4'(exp_b[k]) || done_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL decade_b%0d: got q=%0d done=%b expected q=%0d done=0",
                 k, q_o[1], done_o[1], exp_b[k]);
      end
    end
  endtask

  task automatic test_auto_reload();
    int exp_q[9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
    int pulses = 0;
    int last   = -1;
    ldn = 0; d = 4'd2; enp = 1; ent = 1;
    step();
    ldn = 1;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (q_o[2] !== 4'(exp_q[k]) || done_o[2] !== (exp_q[k] == 0)) begin
        errors++;
        $display("FAIL reload_step%0d: got q=%0d done=%b expected q=%0d done=%b",
                 k, q_o[2], done_o[2], exp_q[k], exp_q[k] == 0);
      end
      if (done_o[2] === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (k - last != 3) begin
            errors++;
            $display("FAIL reload_period: got %0d expected 3", k - last);
          end
        end
        last = k;
        pulses++;
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL reload_pulses: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_clear_priority();
    ldn = 0; d = 4'd5; enp = 0; ent = 0;
    step();
    checks++;
    if (q_o[0] !== 4'd5) begin
      errors++;
      $display("FAIL prio_load5: got %0d expected 5", q_o[0]);
    end
    ldn = 0; d = 4'd7; clr = 1;
    step();
    clr = 0;
    checks++;
    if (q_o[0] !== 4'd0 || rld_o[0] !== 4'd0) begin
      errors++;
      $display("FAIL prio_clr: got q=%0d rld=%0d expected 0/0", q_o[0], rld_o[0]);
    end
    ldn = 0; d = 4'd7; enp = 1; ent = 1;
    step();
    ldn = 1;
    checks++;
    if (q_o[0] !== 4'd7 || rld_o[0] !== 4'd7) begin
      errors++;
      $display("FAIL prio_load_over_count: got q=%0d rld=%0d expected 7/7", q_o[0], rld_o[0]);
    end
  endtask

  task automatic test_cascade();
    cldn = 0; cd = 8'h10; cenp = 1; cent = 1;
    step();
    cldn = 1;
    step();
    checks++;
    if ({hi_q, lo_q} !== 8'h0F || hi_done !== 1'b1 || lo_done !== 1'b0) begin
      errors++;
      $display("FAIL cascade_step: got %h%h done hi/lo=%b%b expected 0F done=10",
               hi_q, lo_q, hi_done, lo_done);
    end
    cenp = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({hi_q, lo_q} !== 8'h0F || hi_done !== 1'b0 || lo_done !== 1'b0) begin
        errors++;
        $display("FAIL cascade_hold%0d: got %h%h done hi/lo=%b%b expected 0F done=00",
                 k, hi_q, lo_q, hi_done, lo_done);
      end
    end
    for (int k = 0; k < 80; k++) begin
      cenp = ($urandom_range(0, 4) != 0);
      cent = ($urandom_range(0, 4) != 0);
      cldn = ($urandom_range(0, 9) != 0);
      cd   = 8'($urandom);
      step();
      checks++;
      if ({hi_q, lo_q} !== 8'(cm)) begin
        errors++;
        $display("FAIL cascade_rand%0d: got %h%h expected %h", k, hi_q, lo_q, 8'(cm));
      end
    end
    cldn = 1; cenp = 0; cent = 0;
  endtask

  task automatic test_random();
    clr = 1;
    step();
    for (int k = 0; k < 300; k++) begin
      clr = ($urandom_range(0, 19) == 0);
      ldn = ($urandom_range(0, 7) != 0);
      enp = ($urandom_range(0, 5) != 0);
      ent = ($urandom_range(0, 5) != 0);
      d   = 4'($urandom);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_o[i] !== 4'(mq[i]) || rld_o[i] !== 4'(mrld[i]) || done_o[i] !== mdone[i] ||
            zero_o[i] !== (mq[i] == 0) || bon_o[i] !== !((mq[i] == 0) && ent)) begin
          errors++;
          $display("FAIL random%0d[%0d]: got q=%0d rld=%0d done=%b zero=%b bon=%b expected q=%0d rld=%0d done=%b zero=%b bon=%b",
                   k, i, q_o[i], rld_o[i], done_o[i], zero_o[i], bon_o[i],
                   mq[i], mrld[i], mdone[i], mq[i] == 0, !((mq[i] == 0) && ent));
        end
      end
    end
    clr = 0; ldn = 1;
  endtask

  initial begin
    clr = 0; ldn = 1; enp = 0; ent = 0; d = '0;
    cclr = 0; cldn = 1; cenp = 0; cent = 0; cd = '0;
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0; mrld[i] = 0; mdone[i] = 0;
    end
    cm = 0;
    @(negedge clk);
    test_reset();
    test_binary_wrap();
    test_decade();
    test_auto_reload();
    test_clear_priority();
    test_cascade();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
